// File: rtl/int_wb_arbiter.sv
// -----------------------------------------------------------------------------
// int_wb_arbiter
//
// Purpose:
//   Merges the four integer producers (MISC, ALU0, ALU1, MDU) onto the two
//   registered integer writeback ports. Each cycle up to two valid sources are
//   granted in round-robin order starting at ptr. The first grant goes to
//   port 0 and the second to port 1. A granted result appears on its port one
//   cycle later for exactly one cycle.
//
// Ports:
//   clk, a_rst_n          clock, asynchronous active-low reset
//   flush_i               pipeline flush: blocks all grants, clears valids/ptr
//   src_valid_i[s]        source s holds a result (0=MISC 1=ALU0 2=ALU1 3=MDU)
//   src_ready_o[s]        source s result accepted this cycle (combinational)
//   src_rob_idx_i/src_preg_i/src_we_i/src_data_i   per-source result fields
//   wb_valid_o[k]         writeback port k valid (registered)
//   wb_rob_idx_o/wb_preg_o/wb_we_o/wb_data_o       per-port result fields
// -----------------------------------------------------------------------------
module int_wb_arbiter #(
    parameter int ROB_IDX_W = 6,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
) (
    input  logic                            clk,
    input  logic                            a_rst_n,
    input  logic                            flush_i,
    input  logic [3:0]                      src_valid_i,
    output logic [3:0]                      src_ready_o,
    input  logic [3:0][ROB_IDX_W-1:0]       src_rob_idx_i,
    input  logic [3:0][PREG_W-1:0]          src_preg_i,
    input  logic [3:0]                      src_we_i,
    input  logic [3:0][DATA_W-1:0]          src_data_i,
    output logic [1:0]                      wb_valid_o,
    output logic [1:0][ROB_IDX_W-1:0]       wb_rob_idx_o,
    output logic [1:0][PREG_W-1:0]          wb_preg_o,
    output logic [1:0]                      wb_we_o,
    output logic [1:0][DATA_W-1:0]          wb_data_o
);

    logic [1:0]                 ptr_q;
    logic [1:0]                 ptr_d;
    logic [1:0]                 gnt_valid_s;
    logic [1:0][1:0]            gnt_src_s;
    logic [3:0]                 grant_s;
    logic [1:0]                 last_src_s;
    logic [1:0]                 wb_valid_q;
    logic [1:0]                 wb_valid_d;
    logic [1:0][ROB_IDX_W-1:0]  wb_rob_idx_q;
    logic [1:0][PREG_W-1:0]     wb_preg_q;
    logic [1:0]                 wb_we_q;
    logic [1:0][DATA_W-1:0]     wb_data_q;

    // Round-robin scan from ptr: first valid source to port 0, second to port 1.
    always_comb begin
        gnt_valid_s  = 2'b00;
        gnt_src_s[0] = 2'd0;
        gnt_src_s[1] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (src_valid_i[ptr_q + 2'(i)]) begin
                if (!gnt_valid_s[0]) begin
                    gnt_valid_s[0] = 1'b1;
                    gnt_src_s[0]   = ptr_q + 2'(i);
                end else if (!gnt_valid_s[1]) begin
                    gnt_valid_s[1] = 1'b1;
                    gnt_src_s[1]   = ptr_q + 2'(i);
                end else begin
                    gnt_valid_s = gnt_valid_s;
                end
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
    end

    // Per-source grant vector, ready gating and next pointer / port valids.
    always_comb begin
        grant_s = 4'b0000;
        if (gnt_valid_s[0]) begin
            grant_s[gnt_src_s[0]] = 1'b1;
        end else begin
            grant_s = grant_s;
        end
        if (gnt_valid_s[1]) begin
            grant_s[gnt_src_s[1]] = 1'b1;
        end else begin
            grant_s = grant_s;
        end

        // Ready is held low in reset so no producer retires a result that
        // the cleared output registers would then drop.
        src_ready_o = grant_s & {4{~flush_i & a_rst_n}};

        // Port 1 is granted only after port 0, so it is the last in scan order.
        if (gnt_valid_s[1]) begin
            last_src_s = gnt_src_s[1];
        end else begin
            last_src_s = gnt_src_s[0];
        end

        if (flush_i) begin
            ptr_d      = 2'd0;
            wb_valid_d = 2'b00;
        end else if (gnt_valid_s[0]) begin
            ptr_d      = last_src_s + 2'd1;
            wb_valid_d = gnt_valid_s;
        end else begin
            ptr_d      = ptr_q;
            wb_valid_d = 2'b00;
        end
    end

    // Pointer, port valids and port payload registers; payload moves only on transfer.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            ptr_q        <= 2'd0;
            wb_valid_q   <= 2'b00;
            wb_rob_idx_q <= '0;
            wb_preg_q    <= '0;
            wb_we_q      <= 2'b00;
            wb_data_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            for (int k = 0; k < 2; k++) begin
                if (gnt_valid_s[k] && !flush_i) begin
                    wb_rob_idx_q[k] <= src_rob_idx_i[gnt_src_s[k]];
                    wb_preg_q[k]    <= src_preg_i[gnt_src_s[k]];
                    wb_we_q[k]      <= src_we_i[gnt_src_s[k]];
                    wb_data_q[k]    <= src_data_i[gnt_src_s[k]];
                end else begin
                    wb_rob_idx_q[k] <= wb_rob_idx_q[k];
                    wb_preg_q[k]    <= wb_preg_q[k];
                    wb_we_q[k]      <= wb_we_q[k];
                    wb_data_q[k]    <= wb_data_q[k];
                end
            end
        end
    end

    assign wb_valid_o   = wb_valid_q;
    assign wb_rob_idx_o = wb_rob_idx_q;
    assign wb_preg_o    = wb_preg_q;
    assign wb_we_o      = wb_we_q;
    assign wb_data_o    = wb_data_q;

endmodule

// File: tb/tb_int_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_int_wb_arbiter
//
// Directed vectors with hand-computed expectations for int_wb_arbiter,
// followed by a short random run checked against a small scan-order model.
// -----------------------------------------------------------------------------
module tb_int_wb_arbiter;

    logic             clk = 1'b0;
    logic             a_rst_n;
    logic             flush_i;
    logic [3:0]       src_valid_i;
    logic [3:0]       src_ready_o;
    logic [3:0][5:0]  src_rob_idx_i;
    logic [3:0][5:0]  src_preg_i;
    logic [3:0]       src_we_i;
    logic [3:0][31:0] src_data_i;
    logic [1:0]       wb_valid_o;
    logic [1:0][5:0]  wb_rob_idx_o;
    logic [1:0][5:0]  wb_preg_o;
    logic [1:0]       wb_we_o;
    logic [1:0][31:0] wb_data_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // random-phase model state
    logic [1:0] mp;
    logic [3:0] eg;
    logic [1:0] ev;
    logic [1:0] es0;
    logic [1:0] es1;
    logic [1:0] idx;
    logic [5:0] erob0;
    logic [5:0] erob1;
    logic       fl;
    int         wait_cnt [4];

    int_wb_arbiter #(.ROB_IDX_W(6), .PREG_W(6), .DATA_W(32)) dut (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .flush_i       (flush_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .src_rob_idx_i (src_rob_idx_i),
        .src_preg_i    (src_preg_i),
        .src_we_i      (src_we_i),
        .src_data_i    (src_data_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rob_idx_o  (wb_rob_idx_o),
        .wb_preg_o     (wb_preg_o),
        .wb_we_o       (wb_we_o),
        .wb_data_o     (wb_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // source s: rob 10+s, preg 20+s, data A0000000+s, we = s[0]
    task automatic load_all();
        for (int s = 0; s < 4; s++) begin
            src_rob_idx_i[s] = 6'(10 + s);
            src_preg_i[s]    = 6'(20 + s);
            src_data_i[s]    = 32'hA000_0000 + 32'(s);
        end
        src_we_i = 4'b1010;
    endtask

    initial begin
        a_rst_n     = 1'b0;
        flush_i     = 1'b0;
        src_valid_i = 4'b1111;
        load_all();
        #2;
        // ---------------- reset state ----------------
        check("rst_ready", 64'(src_ready_o), 64'h0);
        check("rst_valid", 64'(wb_valid_o), 64'h0);
        check("rst_we",    64'(wb_we_o), 64'h0);
        check("rst_rob",   64'(wb_rob_idx_o), 64'h0);
        check("rst_preg",  64'(wb_preg_o), 64'h0);
        check("rst_data",  64'(wb_data_o), 64'h0);
        check("rst_ptr",   64'(dut.ptr_q), 64'h0);
        step();
        check("rst_hold_valid", 64'(wb_valid_o), 64'h0);
        a_rst_n     = 1'b1;
        src_valid_i = 4'b0000;
        step();

        // ---------------- single source ALU0 ----------------
        src_valid_i      = 4'b0010;
        src_rob_idx_i[1] = 6'd5;
        src_preg_i[1]    = 6'd12;
        src_data_i[1]    = 32'hDEAD_BEEF;
        src_we_i         = 4'b0010;
        #1;
        check("single_ready", 64'(src_ready_o), 64'h2);
        step();
        src_valid_i = 4'b0000;
        check("single_valid", 64'(wb_valid_o), 64'h1);
        check("single_rob",   64'(wb_rob_idx_o[0]), 64'd5);
        check("single_preg",  64'(wb_preg_o[0]), 64'd12);
        check("single_data",  64'(wb_data_o[0]), 64'hDEAD_BEEF);
        check("single_we",    64'(wb_we_o[0]), 64'h1);
        check("single_ptr",   64'(dut.ptr_q), 64'd2);
        step();
        check("single_oneshot", 64'(wb_valid_o), 64'h0);
        check("single_hold",    64'(wb_data_o[0]), 64'hDEAD_BEEF);

        // ---------------- flush from idle, then streaming ----------------
        load_all();
        src_valid_i = 4'b1111;
        flush_i     = 1'b1;
        #1;
        check("flush_ready", 64'(src_ready_o), 64'h0);
        step();
        flush_i = 1'b0;
        check("flush_valid", 64'(wb_valid_o), 64'h0);
        check("flush_ptr",   64'(dut.ptr_q), 64'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stream_ready", 64'(src_ready_o), (c % 2 == 0) ? 64'h3 : 64'hC);
            step();
            check("stream_valid", 64'(wb_valid_o), 64'h3);
            check("stream_rob0", 64'(wb_rob_idx_o[0]), (c % 2 == 0) ? 64'd10 : 64'd12);
            check("stream_rob1", 64'(wb_rob_idx_o[1]), (c % 2 == 0) ? 64'd11 : 64'd13);
            check("stream_we",   64'(wb_we_o), (c % 2 == 0) ? 64'h2 : 64'h2);
            check("stream_ptr",  64'(dut.ptr_q), (c % 2 == 0) ? 64'd2 : 64'd0);
        end
        // flush while both ports busy
        flush_i = 1'b1;
        #1;
        check("flush2_ready", 64'(src_ready_o), 64'h0);
        step();
        flush_i = 1'b0;
        check("flush2_valid", 64'(wb_valid_o), 64'h0);
        check("flush2_ptr",   64'(dut.ptr_q), 64'd0);
        check("flush2_data",  64'(wb_data_o[0]), 64'hA000_0002);
        #1;
        check("post_flush_ready", 64'(src_ready_o), 64'h3);
        src_valid_i = 4'b0000;
        step();

        // ---------------- rotation: reach ptr=3, then valid=0101 ----------------
        src_valid_i = 4'b0100;
        #1;
        check("rot_pre_ready", 64'(src_ready_o), 64'h4);
        step();
        check("rot_pre_ptr", 64'(dut.ptr_q), 64'd3);
        src_valid_i = 4'b0101;
        #1;
        check("rot_ready", 64'(src_ready_o), 64'h5);
        step();
        src_valid_i = 4'b0000;
        check("rot_valid", 64'(wb_valid_o), 64'h3);
        check("rot_rob0",  64'(wb_rob_idx_o[0]), 64'd10);
        check("rot_rob1",  64'(wb_rob_idx_o[1]), 64'd12);
        check("rot_ptr",   64'(dut.ptr_q), 64'd3);

        // ---------------- asynchronous reset mid-stream ----------------
        src_valid_i = 4'b1111;
        step();
        // from ptr=3: MDU on port 0, MISC on port 1, ptr -> 1
        check("ar_valid", 64'(wb_valid_o), 64'h3);
        check("ar_rob0",  64'(wb_rob_idx_o[0]), 64'd13);
        check("ar_rob1",  64'(wb_rob_idx_o[1]), 64'd10);
        #3;
        a_rst_n = 1'b0;
        #1;
        check("ar_async_valid", 64'(wb_valid_o), 64'h0);
        check("ar_async_ptr",   64'(dut.ptr_q), 64'd0);
        check("ar_ready",       64'(src_ready_o), 64'h0);
        #1;
        a_rst_n = 1'b1;
        #1;
        check("ar_post_ready", 64'(src_ready_o), 64'h3);
        step();
        check("ar_post_rob0", 64'(wb_rob_idx_o[0]), 64'd10);
        check("ar_post_rob1", 64'(wb_rob_idx_o[1]), 64'd11);

        // ---------------- random run against scan-order model ----------------
        mp = 2'd2;
        for (int s = 0; s < 4; s++) wait_cnt[s] = 0;
        for (int c = 0; c < 400; c++) begin
            src_valid_i = 4'($urandom_range(0, 15));
            for (int s = 0; s < 4; s++) begin
                src_rob_idx_i[s] = 6'($urandom_range(0, 63));
                src_data_i[s]    = $urandom;
            end
            fl      = ($urandom_range(0, 15) == 0);
            flush_i = fl;
            eg = 4'b0000;
            ev = 2'b00;
            es0 = 2'd0;
            es1 = 2'd0;
            for (int i = 0; i < 4; i++) begin
                idx = mp + 2'(i);
                if (src_valid_i[idx] && !ev[0]) begin
                    ev[0] = 1'b1;
                    es0   = idx;
                end else if (src_valid_i[idx] && !ev[1]) begin
                    ev[1] = 1'b1;
                    es1   = idx;
                end
            end
            if (ev[0]) eg[es0] = 1'b1;
            if (ev[1]) eg[es1] = 1'b1;
            if (fl) eg = 4'b0000;
            erob0 = src_rob_idx_i[es0];
            erob1 = src_rob_idx_i[es1];
            #1;
            check("rnd_ready", 64'(src_ready_o), 64'(eg));
            for (int s = 0; s < 4; s++) begin
                if (fl) wait_cnt[s] = 0;
                else if (src_valid_i[s] && !eg[s]) wait_cnt[s]++;
                else wait_cnt[s] = 0;
                if (wait_cnt[s] >= 2) check("rnd_starve", 64'(wait_cnt[s]), 64'd1);
            end
            step();
            check("rnd_valid", 64'(wb_valid_o), fl ? 64'h0 : 64'(ev));
            if (!fl && ev[0]) check("rnd_rob0", 64'(wb_rob_idx_o[0]), 64'(erob0));
            if (!fl && ev[1]) check("rnd_rob1", 64'(wb_rob_idx_o[1]), 64'(erob1));
            if (fl) mp = 2'd0;
            else if (ev[1]) mp = es1 + 2'd1;
            else if (ev[0]) mp = es0 + 2'd1;
        end
        flush_i     = 1'b0;
        src_valid_i = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
